wb_nic: RTL and testbench

Registered, parametrised Wishbone slave-select interconnect between `rv_core` and the SoC peripherals. It replaces the combinational `nic` decode/mux. It adds:
- a request/response state machine;
- a populated-slave mask, with immediate error on holes in the map;
- an optional bus-timeout watchdog;
- a sticky fault-address capture.

It decodes the top `ADDR_SEL_WIDTH` address bits, routes to one of `2**ADDR_SEL_WIDTH` slaves and returns registered data with ack or err.

---
 rtl/wb_nic_pkg.sv | 20 ++
 rtl/wb_nic_wdt.sv | 31 +++
 rtl/wb_nic.sv | 137 +++++++++++++
 tb/tb_wb_nic.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_nic_pkg.sv
// Shared types and constants for the wb_nic slave-select interconnect.
// Optional bus-timeout watchdog is enabled with WB_NIC_TIMEOUT_EN.
package wb_nic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERROR  = 2'd3
  } wb_nic_state_t;

  // Well-known slave indices in the SoC address map.
  localparam int WB_NIC_SLAVE_TCM   = 0;
  localparam int WB_NIC_SLAVE_UART  = 1;
  localparam int WB_NIC_SLAVE_TIMER = 2;

  // Value returned on the read bus with an error pulse.
  localparam int WB_NIC_ERR_DATA = 0;

endpackage

// File: rtl/wb_nic_wdt.sv
// Bus-timeout counter for wb_nic; only instantiated when WB_NIC_TIMEOUT_EN is defined.
// Expires on the LIMIT-th enabled cycle after a clear.
module wb_nic_wdt #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [15:0] cnt_q, cnt_d;

  // Saturate rather than wrap so a stuck enable can never re-arm silently.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)
      cnt_d = '0;
    else if (i_en && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_expired = i_en && (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/wb_nic.sv
// Registered Wishbone slave-select interconnect: decodes the top address bits,
// errors on unpopulated slaves, captures fault address. Timeout via WB_NIC_TIMEOUT_EN.
module wb_nic
  import wb_nic_pkg::*;
#(
  parameter  int ADDR_SEL_WIDTH = 4,
  parameter  int DATA_WIDTH     = 32,
  localparam int N              = 2**ADDR_SEL_WIDTH,
  parameter  logic [N-1:0] SLAVE_MASK = '1,
  parameter  int TIMEOUT_CYCLES = 255
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [31:0]                    i_wb_adr,
  input  logic                           i_wb_we,
  input  logic                           i_wb_stb,
  input  logic                           i_wb_cyc,
  output logic [DATA_WIDTH-1:0]          o_wb_dat,
  output logic                           o_wb_ack,
  output logic                           o_wb_err,
  output logic [N-1:0]                   o_slave_sel,
  input  logic [N-1:0][DATA_WIDTH-1:0]   i_slave_rdata,
  input  logic [N-1:0]                   i_slave_ack,
  output logic [31:0]                    o_fault_addr,
  output logic                           o_fault_valid
);

  wb_nic_state_t             state_q;
  logic [ADDR_SEL_WIDTH-1:0] idx_q;
  logic [31:0]               adr_q;
  logic [DATA_WIDTH-1:0]     dat_q;
  logic                      ack_q, err_q;
  logic [N-1:0]              sel_q;
  logic [31:0]               fault_addr_q;
  logic                      fault_valid_q;

  logic [ADDR_SEL_WIDTH-1:0] req_idx;
  logic                      req_go;
  logic                      sel_ack;
  logic                      wdt_expired;

  assign req_idx = i_wb_adr[31 -: ADDR_SEL_WIDTH];
  assign req_go  = i_wb_cyc && i_wb_stb;
  // Only the latched slave's ack counts; strays from other slaves are dropped.
  assign sel_ack = i_slave_ack[idx_q];

`ifdef WB_NIC_TIMEOUT_EN
  logic wdt_clr, wdt_en;
  assign wdt_clr = (state_q == IDLE) && req_go && SLAVE_MASK[req_idx];
  assign wdt_en  = (state_q == ACCESS);

  wb_nic_wdt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdt (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (wdt_clr),
    .i_en      (wdt_en),
    .o_expired (wdt_expired)
  );

  logic unused_in;
  assign unused_in = i_wb_we;
`else
  assign wdt_expired = 1'b0;

  logic unused_in;
  assign unused_in = ^{i_wb_we, 16'(TIMEOUT_CYCLES)};
`endif

  // Select is registered on the IDLE->ACCESS edge and held for all of ACCESS,
  // giving synchronous-read slaves a full cycle of stable address before ack.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      adr_q         <= '0;
      dat_q         <= '0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      sel_q         <= '0;
      fault_addr_q  <= '0;
      fault_valid_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_go) begin
            idx_q <= req_idx;
            adr_q <= i_wb_adr;
            if (SLAVE_MASK[req_idx]) begin
              sel_q   <= N'(1) << req_idx;
              state_q <= ACCESS;
            end else begin
              state_q <= ERROR;
            end
          end
        end
        ACCESS: begin
          // Abort wins over ack; ack wins over a same-cycle timeout.
          if (!i_wb_cyc) begin
            sel_q   <= '0;
            state_q <= IDLE;
          end else if (sel_ack) begin
            dat_q   <= i_slave_rdata[idx_q];
            sel_q   <= '0;
            state_q <= RESP;
          end else if (wdt_expired) begin
            sel_q   <= '0;
            state_q <= ERROR;
          end
        end
        RESP: begin
          ack_q   <= 1'b1;
          state_q <= IDLE;
        end
        ERROR: begin
          err_q         <= 1'b1;
          dat_q         <= DATA_WIDTH'(WB_NIC_ERR_DATA);
          fault_addr_q  <= adr_q;
          fault_valid_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_dat      = dat_q;
  assign o_wb_ack      = ack_q;
  assign o_wb_err      = err_q;
  assign o_slave_sel   = sel_q;
  assign o_fault_addr  = fault_addr_q;
  assign o_fault_valid = fault_valid_q;

endmodule

// File: tb/tb_wb_nic.sv
// Scoreboard bench for wb_nic: stimulus pushes expected ack/err responses,
// a negedge monitor pops and checks them. Timeout cases need WB_NIC_TIMEOUT_EN.
module tb_wb_nic;
  import wb_nic_pkg::*;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic               clk;
  logic               rst;
  logic [31:0]        adr;
  logic               we, stb, cyc;
  logic [DW-1:0]      o_wb_dat;
  logic               o_wb_ack, o_wb_err;
  logic [N-1:0]       o_slave_sel;
  logic [N-1:0][DW-1:0] rdata;
  logic [N-1:0]       acks;
  logic [31:0]        o_fault_addr;
  logic               o_fault_valid;

  int ntests = 0;
  int nfail  = 0;
  int ecnt   = 0;

  typedef struct {
    logic        is_err;
    int          edge_n;
    logic [31:0] dat;
    logic [31:0] faddr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  wb_nic #(
    .ADDR_SEL_WIDTH (4),
    .DATA_WIDTH     (DW),
    .SLAVE_MASK     (16'h0007),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_wb_adr      (adr),
    .i_wb_we       (we),
    .i_wb_stb      (stb),
    .i_wb_cyc      (cyc),
    .o_wb_dat      (o_wb_dat),
    .o_wb_ack      (o_wb_ack),
    .o_wb_err      (o_wb_err),
    .o_slave_sel   (o_slave_sel),
    .i_slave_rdata (rdata),
    .i_slave_ack   (acks),
    .o_fault_addr  (o_fault_addr),
    .o_fault_valid (o_fault_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, output int e0);
    adr = a; cyc = 1'b1; stb = 1'b1; e0 = ecnt;
  endtask

  task automatic idle();
    adr = '0; cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic push(input logic is_err, input int edge_n, input logic [31:0] d,
                      input logic [31:0] fa);
    exp_t x;
    x.is_err = is_err; x.edge_n = edge_n; x.dat = d; x.faddr = fa;
    exp_q.push_back(x);
  endtask

  // Monitor: every ack/err must match the oldest expectation, on the right edge.
  always @(negedge clk) begin
    if (o_wb_ack || o_wb_err) begin
      if (exp_q.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b at edge %0d, expected none",
                 o_wb_ack, o_wb_err, ecnt);
      end else begin
        e_mon = exp_q.pop_front();
        chk("resp_kind", {o_wb_ack, o_wb_err}, e_mon.is_err ? 2'b01 : 2'b10);
        chk("resp_edge", ecnt, e_mon.edge_n);
        chk("resp_dat", o_wb_dat, e_mon.dat);
        if (e_mon.is_err) begin
          chk("fault_addr", o_fault_addr, e_mon.faddr);
          chk("fault_valid", o_fault_valid, 1);
        end
      end
    end else if (exp_q.size() != 0 && ecnt > exp_q[0].edge_n) begin
      ntests++; nfail++;
      $display("FAIL missing_resp: no response by edge %0d, expected at edge %0d",
               ecnt, exp_q[0].edge_n);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    int e0;
    rst = 1'b1; adr = '0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    rdata = '0; acks = '0;

    // Reset held with a live strobe: nothing may leave reset values.
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("reset_outs", {o_wb_dat, o_wb_ack, o_wb_err, o_slave_sel, o_fault_valid}, 0);
      chk("reset_fault_addr", o_fault_addr, 0);
    end
    rst = 1'b0; idle();
    step(2);

    // TCM read, ack tied high.
    rdata[WB_NIC_SLAVE_TCM] = 32'h1234_5678;
    acks[WB_NIC_SLAVE_TCM]  = 1'b1;
    start(32'h0000_0010, e0);
    push(1'b0, e0 + 3, 32'h1234_5678, 0);
    step(1); chk("tcm_sel", o_slave_sel, 16'h0001);
    step(1); chk("tcm_sel_resp", o_slave_sel, 16'h0000);
    step(1); idle();
    step(2);

    // Slow UART, ack 5 cycles after select, spurious timer ack in between.
    rdata[WB_NIC_SLAVE_UART]  = 32'hA5A5_0001;
    rdata[WB_NIC_SLAVE_TIMER] = 32'hDEAD_0002;
    start(32'h1000_0004, e0);
    push(1'b0, e0 + 7, 32'hA5A5_0001, 0);
    step(1); chk("uart_sel", o_slave_sel, 16'h0002);
    step(1); acks[WB_NIC_SLAVE_TIMER] = 1'b1;
    step(2); chk("uart_sel_spurious", o_slave_sel, 16'h0002);
    acks[WB_NIC_SLAVE_TIMER] = 1'b0;
    step(1); acks[WB_NIC_SLAVE_UART] = 1'b1;
    step(1); acks[WB_NIC_SLAVE_UART] = 1'b0;
    step(1); idle();
    step(2);

    // Hole in the map: slave 5 is unpopulated.
    start(32'h5000_0000, e0);
    push(1'b1, e0 + 2, 32'h0, 32'h5000_0000);
    step(1); chk("hole_sel1", o_slave_sel, 0);
    step(1); chk("hole_sel2", o_slave_sel, 0);
    idle();
    step(2);
    chk("hole_fault_sticky", {o_fault_valid, o_fault_addr}, {1'b1, 32'h5000_0000});

    // Abort on the second ACCESS cycle, then a normal TCM read.
    acks[WB_NIC_SLAVE_TCM] = 1'b0;
    start(32'h0000_0020, e0);
    step(1); chk("abort_sel1", o_slave_sel, 16'h0001);
    step(1); chk("abort_sel2", o_slave_sel, 16'h0001);
    idle();
    step(1); chk("abort_sel_clr", o_slave_sel, 0);
    step(2);
    chk("abort_fault_kept", o_fault_addr, 32'h5000_0000);
    acks[WB_NIC_SLAVE_TCM]  = 1'b1;
    rdata[WB_NIC_SLAVE_TCM] = 32'hCAFE_F00D;
    start(32'h0000_0030, e0);
    push(1'b0, e0 + 3, 32'hCAFE_F00D, 0);
    step(3); idle();
    step(2);

`ifdef WB_NIC_TIMEOUT_EN
    // Timer never acks: TO cycles of ACCESS, then ERROR, err on edge 2+TO.
    start(32'h2000_0000, e0);
    push(1'b1, e0 + 2 + TO, 32'h0, 32'h2000_0000);
    step(TO); chk("to_sel_held", o_slave_sel, 16'h0004);
    step(1);  chk("to_sel_clr", o_slave_sel, 0);
    step(1);  idle();
    step(2);

    // Ack on the limit cycle wins.
    rdata[WB_NIC_SLAVE_TIMER] = 32'h7777_0002;
    start(32'h2000_0040, e0);
    push(1'b0, e0 + 2 + TO, 32'h7777_0002, 0);
    step(TO); acks[WB_NIC_SLAVE_TIMER] = 1'b1;
    step(1);  acks[WB_NIC_SLAVE_TIMER] = 1'b0;
    step(1);  idle();
    step(2);
    chk("to_fault_after_ack", o_fault_addr, 32'h2000_0000);
`else
    // Without the watchdog ACCESS waits indefinitely; leave by aborting.
    start(32'h2000_0000, e0);
    step(40); chk("nowdt_sel_held", o_slave_sel, 16'h0004);
    idle();
    step(1);  chk("nowdt_sel_clr", o_slave_sel, 0);
    step(2);
`endif

    // Reset mid-ACCESS returns everything to reset values.
    start(32'h1000_0000, e0);
    step(2); chk("midrst_sel", o_slave_sel, 16'h0002);
    rst = 1'b1;
    step(1);
    chk("midrst_outs", {o_wb_dat, o_wb_ack, o_wb_err, o_slave_sel, o_fault_valid}, 0);
    chk("midrst_fault_addr", o_fault_addr, 0);
    rst = 1'b0; idle();
    step(3); chk("midrst_idle_sel", o_slave_sel, 0);

    step(5);
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
